// File: rtl/icb_arbiter.sv
// icb_arbiter: two-master round-robin ICB arbiter, one outstanding transfer at a time.
// Optional slave-response watchdog enabled by defining ICB_ARB_TIMEOUT_EN.
module icb_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m0_icb_en_i,
  input  logic [ADDR_W-1:0]   m0_icb_addr_i,
  input  logic [DATA_W-1:0]   m0_icb_wdata_i,
  input  logic [DATA_W/8-1:0] m0_icb_wmask_i,
  output logic [DATA_W-1:0]   m0_icb_rdata_o,
  output logic                m0_icb_ready_o,
  input  logic                m1_icb_en_i,
  input  logic [ADDR_W-1:0]   m1_icb_addr_i,
  input  logic [DATA_W-1:0]   m1_icb_wdata_i,
  input  logic [DATA_W/8-1:0] m1_icb_wmask_i,
  output logic [DATA_W-1:0]   m1_icb_rdata_o,
  output logic                m1_icb_ready_o,
  output logic                s_icb_en_o,
  output logic [ADDR_W-1:0]   s_icb_addr_o,
  output logic [DATA_W-1:0]   s_icb_wdata_o,
  output logic [DATA_W/8-1:0] s_icb_wmask_o,
  input  logic [DATA_W-1:0]   s_icb_rdata_i,
  input  logic                s_icb_ready_i,
  output logic                arb_err_o
);
  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_e;
  state_e state_q, state_d;
  logic last_q, last_d;
  logic busy, sel1, tmo, done;
  logic [DATA_W-1:0] rdata;
`ifdef ICB_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic err_q, err_d;
  // A slave ready in the watchdog cycle wins, so the abort is masked by it.
  always_comb begin
    tmo = busy && cnt_q == 16'(TIMEOUT) && !s_icb_ready_i;
    cnt_d = busy ? cnt_q + 16'd1 : 16'd0;
    err_d = err_q | tmo;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign arb_err_o = err_q;
`else
  assign tmo = 1'b0;
  assign arb_err_o = 1'b0;
`endif
  always_comb begin
    busy = state_q != IDLE;
    sel1 = state_q == BUSY1;
    done = busy && (s_icb_ready_i || tmo);
    rdata = tmo ? ERR_DATA : s_icb_rdata_i;
    // last_q==1 means master 1 was served last, so master 0 wins a tie.
    state_d = !busy ? (m0_icb_en_i && (!m1_icb_en_i || last_q) ? BUSY0 : m1_icb_en_i ? BUSY1 : IDLE)
                    : done ? IDLE : state_q;
    last_d = done ? sel1 : last_q;
    s_icb_en_o = busy && !tmo;
    s_icb_addr_o = !busy ? '0 : sel1 ? m1_icb_addr_i : m0_icb_addr_i;
    s_icb_wdata_o = !busy ? '0 : sel1 ? m1_icb_wdata_i : m0_icb_wdata_i;
    s_icb_wmask_o = !busy ? '0 : sel1 ? m1_icb_wmask_i : m0_icb_wmask_i;
    m0_icb_rdata_o = state_q == BUSY0 ? rdata : '0;
    m1_icb_rdata_o = sel1 ? rdata : '0;
    m0_icb_ready_o = state_q == BUSY0 && done;
    m1_icb_ready_o = sel1 && done;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
    end
  end
endmodule

// File: tb/tb_icb_arbiter.sv
// tb_icb_arbiter: scoreboard bench for icb_arbiter with queued master drivers and a delay-programmable slave.
// Define ICB_ARB_TIMEOUT_EN to also exercise the watchdog with TIMEOUT=8.
module tb_icb_arbiter;
`ifdef ICB_ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif
  localparam logic [31:0] JUNK = 32'h0BAD_0BAD;
  typedef struct {
    int id;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0] wmask;
    logic [31:0] rdata;
  } job_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m0_en, m1_en, s_ready, s_en, m0_ready, m1_ready, arb_err;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, m0_rdata, m1_rdata, s_addr, s_wdata, s_rdata;
  logic [3:0] m0_wmask, m1_wmask, s_wmask;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int slv_dly = 1;
  int wcnt = 0;
  int gnt_cyc = 0;
  int rdy_cyc = 0;
  int gap = 0;
  int req0_cyc = 0;
  bit abort = 1'b0;
  bit prev_en = 1'b0;
  job_t q0[$], q1[$], exp_q[$];

  icb_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_icb_en_i(m0_en), .m0_icb_addr_i(m0_addr), .m0_icb_wdata_i(m0_wdata), .m0_icb_wmask_i(m0_wmask),
    .m0_icb_rdata_o(m0_rdata), .m0_icb_ready_o(m0_ready),
    .m1_icb_en_i(m1_en), .m1_icb_addr_i(m1_addr), .m1_icb_wdata_i(m1_wdata), .m1_icb_wmask_i(m1_wmask),
    .m1_icb_rdata_o(m1_rdata), .m1_icb_ready_o(m1_ready),
    .s_icb_en_o(s_en), .s_icb_addr_o(s_addr), .s_icb_wdata_o(s_wdata), .s_icb_wmask_o(s_wmask),
    .s_icb_rdata_i(s_rdata), .s_icb_ready_i(s_ready), .arb_err_o(arb_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm, input logic [31:0] rd);
    job_t j;
    j.id = id; j.addr = a; j.wdata = wd; j.wmask = wm; j.rdata = rd;
    if (id == 0) q0.push_back(j); else q1.push_back(j);
    exp_q.push_back(j);
  endtask

  task automatic flush();
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #2 abort = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 && !m0_en && !m1_en) break;
    end
    if (n == budget) begin
      chk({nm, "_budget"}, exp_q.size(), 0);
      flush();
    end
  endtask

  task automatic wait_en(input string nm, input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge clk); #1;
      if (s_en) break;
    end
    if (n == budget) chk({nm, "_wait_en"}, s_en, 1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_s_en"}, s_en, 0);
    chk({nm, "_s_addr"}, s_addr, 0);
    chk({nm, "_s_wdata"}, s_wdata, 0);
    chk({nm, "_s_wmask"}, s_wmask, 0);
    chk({nm, "_m0_ready"}, m0_ready, 0);
    chk({nm, "_m0_rdata"}, m0_rdata, 0);
    chk({nm, "_m1_ready"}, m1_ready, 0);
    chk({nm, "_m1_rdata"}, m1_rdata, 0);
    chk({nm, "_arb_err"}, arb_err, 0);
  endtask

  // Master drivers: hold each request until its ready, reload back-to-back from the job queue.
  initial begin
    job_t j;
    bit d0, d1;
    m0_en = 0; m0_addr = 0; m0_wdata = 0; m0_wmask = 0;
    m1_en = 0; m1_addr = 0; m1_wdata = 0; m1_wmask = 0;
    forever begin
      @(negedge clk);
      d0 = m0_ready;
      d1 = m1_ready;
      @(posedge clk); #1;
      if (d0 || abort) m0_en = 0;
      if (d1 || abort) m1_en = 0;
      if (abort) begin
        q0.delete();
        q1.delete();
      end
      if (!m0_en && q0.size() > 0) begin
        j = q0.pop_front();
        m0_en = 1; m0_addr = j.addr; m0_wdata = j.wdata; m0_wmask = j.wmask;
        req0_cyc = cyc;
      end
      if (!m1_en && q1.size() > 0) begin
        j = q1.pop_front();
        m1_en = 1; m1_addr = j.addr; m1_wdata = j.wdata; m1_wmask = j.wmask;
      end
    end
  end

  // Slave: ready slv_dly cycles after s_en rises; one fixed address, inverted address elsewhere.
  initial begin
    s_ready = 0;
    s_rdata = JUNK;
    forever begin
      @(posedge clk); #1;
      if (s_ready) begin
        s_ready = 0;
        s_rdata = JUNK;
        wcnt = 0;
      end else if (s_en) begin
        if (wcnt >= slv_dly) begin
          s_ready = 1;
          s_rdata = (s_addr == 32'h0001_0000) ? 32'h1234_5678 : ~s_addr;
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  // Monitor: checks slave-side fields against the head of the scoreboard and pops on each master ready.
  initial begin
    job_t h;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (s_en && !prev_en) begin
          gap = cyc - rdy_cyc;
          gnt_cyc = cyc;
        end
        if (s_en) begin
          if (exp_q.size() == 0) chk("unexpected_grant", s_en, 0);
          else begin
            h = exp_q[0];
            chk("s_addr", s_addr, h.addr);
            chk("s_wdata", s_wdata, h.wdata);
            chk("s_wmask", s_wmask, h.wmask);
            chk("ungranted_ready", h.id == 1 ? m0_ready : m1_ready, 0);
            chk("ungranted_rdata", h.id == 1 ? m0_rdata : m1_rdata, 0);
          end
        end
        if (m0_ready || m1_ready) begin
          rdy_cyc = cyc;
          if (exp_q.size() == 0) chk("unexpected_ready", {m1_ready, m0_ready}, 0);
          else begin
            h = exp_q.pop_front();
            chk("ready_id", {m1_ready, m0_ready}, h.id == 1 ? 2 : 1);
            chk("rdata", h.id == 1 ? m1_rdata : m0_rdata, h.rdata);
            chk("other_rdata", h.id == 1 ? m0_rdata : m1_rdata, 0);
          end
        end
      end
      prev_en = s_en;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1 rst = 0;
    // Simultaneous requests from reset alternate m0,m1,m0,m1.
    @(negedge clk);
    slv_dly = 1;
    issue(0, 32'h4000_0000, 32'hCAFE_0001, 4'b1111, ~32'h4000_0000);
    issue(1, 32'h4000_0004, 32'h0, 4'b0000, ~32'h4000_0004);
    issue(0, 32'h4000_0008, 32'hCAFE_0002, 4'b0011, ~32'h4000_0008);
    issue(1, 32'h4000_000C, 32'h0, 4'b0000, ~32'h4000_000C);
    wait_done("t2", 80);
    chk("t2_regrant_gap", gap, 2);
    // Lone m0 read: grant at T+1, ready two cycles later.
    slv_dly = 2;
    issue(0, 32'h0001_0000, 32'h0, 4'b0000, 32'h1234_5678);
    wait_done("t1", 40);
    chk("t1_grant_lat", gnt_cyc - req0_cyc, 1);
    chk("t1_ready_lat", rdy_cyc - gnt_cyc, 2);
    chk("t1_idle_en", s_en, 0);
    // m1 arrives while m0 is stalled for 10 cycles.
    slv_dly = 10;
    issue(0, 32'h5000_0000, 32'h1111_2222, 4'b0101, ~32'h5000_0000);
    wait_en("t3", 10);
    repeat (3) @(negedge clk);
    issue(1, 32'h6000_0000, 32'h0, 4'b0000, ~32'h6000_0000);
    wait_done("t3", 80);
    chk("t3_m1_gap", gap, 2);
    chk("t3_stall_len", rdy_cyc - gnt_cyc, 10);
    // Ready in the grant cycle.
    slv_dly = 0;
    issue(0, 32'h7000_0000, 32'h7777_0000, 4'b1000, ~32'h7000_0000);
    wait_done("t4", 40);
    chk("t4_same_cycle", rdy_cyc - gnt_cyc, 0);
    chk("t4_grant_lat", gnt_cyc - req0_cyc, 1);
    chk("t4_idle_next", s_en, 0);
    // Reset during BUSY1, then a tie must go to m0.
    slv_dly = 1000;
    issue(1, 32'h8000_0000, 32'h3333_4444, 4'b1111, ~32'h8000_0000);
    wait_en("t5", 10);
    @(posedge clk); #1;
    rst = 1;
    abort = 1;
    @(posedge clk); #2;
    rst = 0;
    abort = 0;
    exp_q.delete();
    @(negedge clk);
    chk_zero("t5_after_rst");
    slv_dly = 1;
    issue(0, 32'h9000_0000, 32'h0, 4'b0000, ~32'h9000_0000);
    issue(1, 32'h9000_0004, 32'h0, 4'b0000, ~32'h9000_0004);
    wait_done("t5", 60);
`ifdef ICB_ARB_TIMEOUT_EN
    // Silent slave: watchdog abort after 8 BUSY cycles, sticky error.
    slv_dly = 1000;
    issue(0, 32'hA000_0000, 32'h0, 4'b0000, 32'hDEAD_BEEF);
    wait_done("t6", 40);
    chk("t6_tmo_lat", rdy_cyc - gnt_cyc, 8);
    chk("t6_err", arb_err, 1);
    repeat (5) @(negedge clk);
    chk("t6_err_sticky", arb_err, 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("t6_err_cleared", arb_err, 0);
    // Slave ready in the watchdog cycle completes normally.
    slv_dly = 8;
    issue(0, 32'hA000_0010, 32'h0, 4'b0000, ~32'hA000_0010);
    wait_done("t7", 40);
    chk("t7_ready_lat", rdy_cyc - gnt_cyc, 8);
    chk("t7_no_err", arb_err, 0);
`else
    chk("err_tied", arb_err, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
